display_menu_sel: RTL and testbench

Parametrised display-source menu for the seven-segment path. Selects one of `NUM_CH` zero-extended measurement channels (XADC, PWM, R2R raw/averaged/scaled, switches, and others) either directly from slide switches or by stepping with up/down buttons. Each channel carries its own decimal-point pattern. A channel change blanks the display for a fixed window. The block sits between the measurement/averaging/scaling modules and the seven-segment driver, and replaces the fixed 4-switch menu FSM.

---
 rtl/menu_pkg.sv | 12 +
 rtl/btn_edge_det.sv | 18 +
 rtl/display_menu_sel.sv | 154 +++++++++++++++
 tb/tb_display_menu_sel.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared types for the seven-segment display-source menu.
package menu_pkg;

    typedef enum logic {
        MENU_SHOW  = 1'b0,
        MENU_BLANK = 1'b1
    } menu_state_t;

    localparam logic MODE_SWITCH = 1'b0;
    localparam logic MODE_BUTTON = 1'b1;

endpackage

// File: rtl/btn_edge_det.sv
// Rising-edge detector for an already debounced button level.
module btn_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_lvl,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_prev <= 1'b0;
        else      r_prev <= i_lvl;
    end

    assign o_rise = i_lvl & ~r_prev;

endmodule

// File: rtl/display_menu_sel.sv
// Display-source menu: switch or button channel select with blanking.
// Optional auto-scroll in button mode when MENU_AUTOSCROLL_EN is defined.
module display_menu_sel
    import menu_pkg::*;
#(
    parameter int NUM_CH        = 16,
    parameter int DATA_W        = 16,
    parameter int BLANK_CYCLES  = 4,
    parameter int SCROLL_CYCLES = 100_000_000,
    localparam int SEL_W        = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH*4-1:0]      ch_dp,
    input  logic [SEL_W-1:0]         sw_sel,
    input  logic                     sw_mode,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     auto_en,
    output logic [DATA_W-1:0]        mux_out,
    output logic [3:0]               decimal_point,
    output logic [SEL_W-1:0]         cur_ch,
    output logic                     ch_changed
);

    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LD =
        BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    menu_state_t       r_state;
    logic [BW-1:0]     r_cnt;
    logic [SEL_W-1:0]  r_cur_ch;
    logic              r_ch_changed;
    logic [DATA_W-1:0] r_mux;
    logic [3:0]        r_dp;

    logic w_up;
    logic w_dn;
    logic w_auto;
    logic w_step_up;
    logic w_step_dn;
    logic w_sel_ok;
    logic w_chg;
    logic [SEL_W-1:0] w_next;
    logic [DATA_W-1:0] w_word;
    logic [3:0] w_dp;

    btn_edge_det u_up (
        .clk    (clk),
        .rst    (rst),
        .i_lvl  (btn_up),
        .o_rise (w_up)
    );

    btn_edge_det u_dn (
        .clk    (clk),
        .rst    (rst),
        .i_lvl  (btn_down),
        .o_rise (w_dn)
    );

`ifdef MENU_AUTOSCROLL_EN
    localparam int SCW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
    localparam logic [SCW-1:0] SC_LAST = SCW'(SCROLL_CYCLES - 1);

    logic [SCW-1:0] r_scroll;
    logic           r_mode_q;
    logic           w_scroll_run;

    // Any manual interaction restarts the scroll period.
    assign w_scroll_run = (sw_mode == MODE_BUTTON) && auto_en &&
                          !w_up && !w_dn && (sw_mode == r_mode_q);
    assign w_auto = w_scroll_run && (r_scroll == SC_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scroll <= '0;
            r_mode_q <= MODE_SWITCH;
        end else begin
            r_mode_q <= sw_mode;
            if (!w_scroll_run || w_auto) r_scroll <= '0;
            else                         r_scroll <= r_scroll + SCW'(1);
        end
    end
`else
    logic w_unused;
    assign w_unused = auto_en;
    assign w_auto   = 1'b0;
`endif

    assign w_step_up = (w_up & ~w_dn) | w_auto;
    assign w_step_dn = w_dn & ~w_up;
    assign w_sel_ok  = 32'(sw_sel) < NUM_CH;

    always_comb begin
        w_next = r_cur_ch;
        w_chg  = 1'b0;
        if (sw_mode == MODE_SWITCH) begin
            if (sw_sel != r_cur_ch && w_sel_ok) begin
                w_next = sw_sel;
                w_chg  = 1'b1;
            end
        end else if (w_step_up) begin
            w_next = (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + SEL_W'(1);
            w_chg  = 1'b1;
        end else if (w_step_dn) begin
            w_next = (r_cur_ch == '0) ? LAST_CH : r_cur_ch - SEL_W'(1);
            w_chg  = 1'b1;
        end
    end

    assign w_word = ch_data[int'(r_cur_ch)*DATA_W +: DATA_W];
    assign w_dp   = ch_dp[int'(r_cur_ch)*4 +: 4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= MENU_SHOW;
            r_cnt        <= '0;
            r_cur_ch     <= '0;
            r_ch_changed <= 1'b0;
            r_mux        <= '0;
            r_dp         <= '0;
        end else begin
            r_cur_ch     <= w_next;
            r_ch_changed <= w_chg;
            unique case (r_state)
                MENU_SHOW: begin
                    r_mux <= w_word;
                    r_dp  <= w_dp;
                end
                MENU_BLANK: begin
                    r_mux <= '0;
                    r_dp  <= '0;
                    if (r_cnt == '0) r_state <= MENU_SHOW;
                    else             r_cnt   <= r_cnt - BW'(1);
                end
                default: r_state <= MENU_SHOW;
            endcase
            // A change while blanking restarts the full blank window.
            if (w_chg && BLANK_CYCLES > 0) begin
                r_state <= MENU_BLANK;
                r_cnt   <= BLANK_LD;
            end
        end
    end

    assign mux_out       = r_mux;
    assign decimal_point = r_dp;
    assign cur_ch        = r_cur_ch;
    assign ch_changed    = r_ch_changed;

endmodule

// File: tb/tb_display_menu_sel.sv
// Directed bench for display_menu_sel (NUM_CH=16, BLANK=4, SCROLL=8).
module tb_display_menu_sel;

    localparam int NUM_CH = 16;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH*4-1:0]      ch_dp;
    logic [SEL_W-1:0]         sw_sel;
    logic                     sw_mode;
    logic                     btn_up;
    logic                     btn_down;
    logic                     auto_en;
    logic [DATA_W-1:0]        mux_out;
    logic [3:0]               decimal_point;
    logic [SEL_W-1:0]         cur_ch;
    logic                     ch_changed;

    int checks = 0;
    int passes = 0;
    int pulses;

    display_menu_sel #(
        .NUM_CH        (NUM_CH),
        .DATA_W        (DATA_W),
        .BLANK_CYCLES  (4),
        .SCROLL_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ch_data       (ch_data),
        .ch_dp         (ch_dp),
        .sw_sel        (sw_sel),
        .sw_mode       (sw_mode),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .auto_en       (auto_en),
        .mux_out       (mux_out),
        .decimal_point (decimal_point),
        .cur_ch        (cur_ch),
        .ch_changed    (ch_changed)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] chv(input int i);
        if (i == 3) return 16'h0ABC;
        return 16'h1000 + 16'(i * 16'h0101);
    endfunction

    function automatic logic [3:0] dpv(input int i);
        if (i == 3) return 4'b1000;
        return 4'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i*DATA_W +: DATA_W] = chv(i);
            ch_dp[i*4 +: 4]             = dpv(i);
        end
        rst = 1'b0; sw_sel = '0; sw_mode = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; auto_en = 1'b0;
        #3;
        chk("rst_mux", 32'(mux_out), 32'h0);
        chk("rst_dp", 32'(decimal_point), 32'h0);
        chk("rst_cur", 32'(cur_ch), 32'h0);
        chk("rst_chg", 32'(ch_changed), 32'h0);
        step(); step();
        rst = 1'b1;
        step();
        chk("first_mux", 32'(mux_out), 32'(chv(0)));
        chk("first_cur", 32'(cur_ch), 32'h0);

        // 1: switch select channel 3
        sw_sel = 4'd3;
        step();
        chk("t1_cur", 32'(cur_ch), 32'd3);
        chk("t1_chg", 32'(ch_changed), 32'd1);
        chk("t1_old", 32'(mux_out), 32'(chv(0)));
        pulses = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            pulses += int'(ch_changed);
            chk("t1_blank", 32'(mux_out), 32'h0);
            chk("t1_blank_dp", 32'(decimal_point), 32'h0);
        end
        step();
        pulses += int'(ch_changed);
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk("t1_data", 32'(mux_out), 32'h0ABC);
        chk("t1_dp", 32'(decimal_point), 32'h8);

        // 2: held up button wraps 15 -> 0 once
        sw_sel = 4'd15;
        for (int i = 0; i < 6; i++) step();
        chk("t2_pre", 32'(cur_ch), 32'd15);
        sw_mode = 1'b1;
        sw_sel = 4'd2;
        step();
        chk("t2_mode", 32'(cur_ch), 32'd15);
        btn_up = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            pulses += int'(ch_changed);
        end
        chk("t2_up_pulses", 32'(pulses), 32'd1);
        chk("t2_up_cur", 32'(cur_ch), 32'd0);
        btn_up = 1'b0;
        step();
        btn_down = 1'b1;
        step();
        chk("t2_dn_cur", 32'(cur_ch), 32'd15);
        chk("t2_dn_chg", 32'(ch_changed), 32'd1);
        btn_down = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t2_dn_data", 32'(mux_out), 32'(chv(15)));
        chk("t2_dn_dp", 32'(decimal_point), 32'(dpv(15)));

        // 3: simultaneous up and down
        btn_up = 1'b1; btn_down = 1'b1;
        step();
        chk("t3_cur", 32'(cur_ch), 32'd15);
        chk("t3_chg", 32'(ch_changed), 32'd0);
        step();
        chk("t3_mux", 32'(mux_out), 32'(chv(15)));
        btn_up = 1'b0; btn_down = 1'b0;
        step();

        // 4: second press during blank extends it
        btn_up = 1'b1;
        step();
        chk("t4_k_cur", 32'(cur_ch), 32'd0);
        btn_up = 1'b0;
        step();
        chk("t4_k1_mux", 32'(mux_out), 32'h0);
        btn_up = 1'b1;
        step();
        chk("t4_k2_cur", 32'(cur_ch), 32'd1);
        chk("t4_k2_chg", 32'(ch_changed), 32'd1);
        btn_up = 1'b0;
        for (int i = 3; i <= 6; i++) begin
            step();
            chk("t4_blank", 32'(mux_out), 32'h0);
        end
        step();
        chk("t4_k7_mux", 32'(mux_out), 32'(chv(1)));

        // 5: async reset in the middle of a blank window
        btn_up = 1'b1;
        step();
        chk("t5_cur", 32'(cur_ch), 32'd2);
        step();
        chk("t5_blank", 32'(mux_out), 32'h0);
        btn_up = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("t5_rst_cur", 32'(cur_ch), 32'd0);
        chk("t5_rst_mux", 32'(mux_out), 32'h0);
        chk("t5_rst_chg", 32'(ch_changed), 32'h0);
        step();
        rst = 1'b1;
        step();
        chk("t5_rel_cur", 32'(cur_ch), 32'd0);
        chk("t5_rel_mux", 32'(mux_out), 32'(chv(0)));

        // 6: auto-scroll
        auto_en = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("t6_7", 32'(cur_ch), 32'd0);
        step();
`ifdef MENU_AUTOSCROLL_EN
        chk("t6_8", 32'(cur_ch), 32'd1);
        for (int i = 0; i < 8; i++) step();
        chk("t6_16", 32'(cur_ch), 32'd2);
`else
        chk("t6_8", 32'(cur_ch), 32'd0);
        for (int i = 0; i < 8; i++) step();
        chk("t6_16", 32'(cur_ch), 32'd0);
`endif
        auto_en = 1'b0;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
